// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default format, sequencer states, flag positions,
// special encodings and the unpacked-operand record with its unpack helper.
package fpu_pkg;

   localparam int FPU_EXP_W = 8;
   localparam int FPU_MAN_W = 23;
   localparam int FPU_W     = 1 + FPU_EXP_W + FPU_MAN_W;
   localparam int FPU_EXT_W = FPU_MAN_W + 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_t;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   localparam logic [3:0] FLAGS_NONE    = 4'b0000;
   localparam logic [3:0] FLAGS_INVALID = 4'(1 << FLAG_INVALID);
   localparam logic [3:0] FLAGS_INEXACT = 4'(1 << FLAG_INEXACT);
   localparam logic [3:0] FLAGS_OVF     = 4'((1 << FLAG_OVERFLOW) | (1 << FLAG_INEXACT));
   localparam logic [3:0] FLAGS_UNF     = 4'((1 << FLAG_UNDERFLOW) | (1 << FLAG_INEXACT));

   localparam logic [FPU_W-1:0] QNAN    = {1'b0, {FPU_EXP_W{1'b1}}, 1'b1, {(FPU_MAN_W-1){1'b0}}};
   localparam logic [FPU_W-2:0] INF_MAG = {{FPU_EXP_W{1'b1}}, {FPU_MAN_W{1'b0}}};

   typedef struct packed {
      logic                 sign;
      logic [FPU_EXP_W-1:0] exp;
      logic [FPU_EXT_W-1:0] man;
      logic                 is_zero;
      logic                 is_inf;
      logic                 is_nan;
   } operand_t;

   // Subnormals are treated as zero: their extended mantissa is forced to 0.
   function automatic operand_t unpack_op(input logic [FPU_W-1:0] v, input logic flip);
      operand_t             o;
      logic [FPU_EXP_W-1:0] e;
      logic [FPU_MAN_W-1:0] f;
      e         = v[FPU_W-2:FPU_MAN_W];
      f         = v[FPU_MAN_W-1:0];
      o.sign    = v[FPU_W-1] ^ flip;
      o.exp     = e;
      o.is_zero = (e == '0);
      o.is_inf  = (e == '1) && (f == '0);
      o.is_nan  = (e == '1) && (f != '0);
      o.man     = o.is_zero ? '0 : {1'b1, f, 3'b000};
      return o;
   endfunction

endpackage

// File: rtl/fpu_alu_big.sv
// Combinational sign-magnitude adder/subtractor; result magnitude keeps the carry bit.
module fpu_alu_big
   import fpu_pkg::*;
#(
   parameter int WIDTH = FPU_EXT_W
) (
   input  logic             op,
   input  logic             a_sign,
   input  logic [WIDTH-1:0] a_mag,
   input  logic             b_sign,
   input  logic [WIDTH-1:0] b_mag,
   output logic             r_sign,
   output logic [WIDTH:0]   r_mag
);

   logic b_eff;

   always_comb begin
      b_eff  = b_sign ^ op;
      r_sign = a_sign;
      r_mag  = '0;
      if (a_sign == b_eff) begin
         r_mag  = {1'b0, a_mag} + {1'b0, b_mag};
         r_sign = a_sign;
      end else if (a_mag >= b_mag) begin
         r_mag  = {1'b0, a_mag - b_mag};
         r_sign = a_sign;
      end else begin
         r_mag  = {1'b0, b_mag - a_mag};
         r_sign = b_eff;
      end
   end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 add/sub sequencer (align, add, normalize, round, pack).
// Define FPU_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub_seq
   import fpu_pkg::*;
#(
   parameter int EXP_W = FPU_EXP_W,
   parameter int MAN_W = FPU_MAN_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_op,
   input  logic [EXP_W+MAN_W:0]       in_a,
   input  logic [EXP_W+MAN_W:0]       in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [EXP_W+MAN_W:0]       out_result,
   output logic [3:0]                 out_flags
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int EXT_W = MAN_W + 4;
   localparam int XE_W  = EXP_W + 1;

   localparam logic [EXP_W-1:0] D_MAX   = EXP_W'(MAN_W + 3);
   localparam logic [XE_W-1:0]  EXP_MAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [XE_W-1:0]  EXP_ONE = XE_W'(1);

   state_t             state_reg;
   logic               in_ready_reg;
   logic               out_valid_reg;
   logic [W-1:0]       result_reg;
   logic [3:0]         flags_reg;
   logic               a_sign_reg;
   logic               b_sign_reg;
   logic [EXT_W-1:0]   a_man_reg;
   logic [EXT_W-1:0]   b_man_reg;
   logic [XE_W-1:0]    exp_reg;
   logic [EXP_W-1:0]   d_reg;
   logic [EXT_W:0]     mag_reg;
   logic               sign_reg;

   operand_t           op_a;
   operand_t           op_b;
   logic               swap;
   logic               special_hit;
   logic [W-1:0]       special_result;
   logic [3:0]         special_flags;

   logic               alu_sign;
   logic [EXT_W:0]     alu_mag;

   logic [MAN_W:0]     rnd_man;
   logic               rnd_g;
   logic               rnd_r;
   logic               rnd_s;
   logic               rnd_inc;
   logic [MAN_W+1:0]   rnd_sum;
   logic [MAN_W-1:0]   rnd_frac;
   logic [XE_W-1:0]    rnd_exp;

   assign in_ready   = in_ready_reg;
   assign out_valid  = out_valid_reg;
   assign out_result = result_reg;
   assign out_flags  = flags_reg;

   // b carries the subtract already folded into its sign, so the datapath only adds.
   fpu_alu_big #(.WIDTH(EXT_W)) u_alu (
      .op     (1'b0),
      .a_sign (a_sign_reg),
      .a_mag  (a_man_reg),
      .b_sign (b_sign_reg),
      .b_mag  (b_man_reg),
      .r_sign (alu_sign),
      .r_mag  (alu_mag)
   );

   always_comb begin
      op_a           = unpack_op(in_a, 1'b0);
      op_b           = unpack_op(in_b, in_op);
      swap           = op_b.exp > op_a.exp;
      special_hit    = 1'b1;
      special_result = '0;
      special_flags  = FLAGS_NONE;
      if (op_a.is_nan || op_b.is_nan) begin
         special_result = QNAN;
      end else if (op_a.is_inf && op_b.is_inf && (op_a.sign != op_b.sign)) begin
         special_result = QNAN;
         special_flags  = FLAGS_INVALID;
      end else if (op_a.is_inf) begin
         special_result = {op_a.sign, INF_MAG};
      end else if (op_b.is_inf) begin
         special_result = {op_b.sign, INF_MAG};
      end else if (op_a.is_zero && op_b.is_zero) begin
         special_result = {op_a.sign & op_b.sign, {(W-1){1'b0}}};
      end else begin
         special_hit = 1'b0;
      end
   end

   always_comb begin
      rnd_man = mag_reg[EXT_W-1:3];
      rnd_g   = mag_reg[2];
      rnd_r   = mag_reg[1];
      rnd_s   = mag_reg[0];
`ifdef FPU_RNE_EN
      rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_man[0]);
`else
      rnd_inc = 1'b0;
`endif
      rnd_sum = {1'b0, rnd_man} + {{(MAN_W+1){1'b0}}, rnd_inc};
      if (rnd_sum[MAN_W+1]) begin
         rnd_frac = rnd_sum[MAN_W:1];
         rnd_exp  = exp_reg + EXP_ONE;
      end else begin
         rnd_frac = rnd_sum[MAN_W-1:0];
         rnd_exp  = exp_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         flags_reg     <= '0;
         a_sign_reg    <= 1'b0;
         b_sign_reg    <= 1'b0;
         a_man_reg     <= '0;
         b_man_reg     <= '0;
         exp_reg       <= '0;
         d_reg         <= '0;
         mag_reg       <= '0;
         sign_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid && in_ready_reg) begin
                  in_ready_reg <= 1'b0;
                  if (special_hit) begin
                     result_reg    <= special_result;
                     flags_reg     <= special_flags;
                     out_valid_reg <= 1'b1;
                     state_reg     <= ST_DONE;
                  end else begin
                     if (swap) begin
                        a_sign_reg <= op_b.sign;
                        a_man_reg  <= op_b.man;
                        b_sign_reg <= op_a.sign;
                        b_man_reg  <= op_a.man;
                        exp_reg    <= {1'b0, op_b.exp};
                        d_reg      <= op_b.exp - op_a.exp;
                     end else begin
                        a_sign_reg <= op_a.sign;
                        a_man_reg  <= op_a.man;
                        b_sign_reg <= op_b.sign;
                        b_man_reg  <= op_b.man;
                        exp_reg    <= {1'b0, op_a.exp};
                        d_reg      <= op_a.exp - op_b.exp;
                     end
                     state_reg <= ST_ALIGN;
                  end
               end
            end
            ST_ALIGN: begin
               if (d_reg > D_MAX) begin
                  // Whole of B would fall below S anyway; keep only its sticky.
                  b_man_reg <= {{(EXT_W-1){1'b0}}, |b_man_reg};
                  d_reg     <= '0;
                  state_reg <= ST_ADD;
               end else if (d_reg == '0) begin
                  state_reg <= ST_ADD;
               end else begin
                  b_man_reg <= {1'b0, b_man_reg[EXT_W-1:2], b_man_reg[1] | b_man_reg[0]};
                  d_reg     <= d_reg - 1'b1;
               end
            end
            ST_ADD: begin
               mag_reg   <= alu_mag;
               sign_reg  <= alu_sign;
               state_reg <= ST_NORM;
            end
            ST_NORM: begin
               if (mag_reg == '0) begin
                  result_reg    <= '0;
                  flags_reg     <= FLAGS_NONE;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_DONE;
               end else if (mag_reg[EXT_W]) begin
                  mag_reg   <= {1'b0, mag_reg[EXT_W:2], mag_reg[1] | mag_reg[0]};
                  exp_reg   <= exp_reg + EXP_ONE;
                  state_reg <= ST_ROUND;
               end else if (mag_reg[EXT_W-1]) begin
                  state_reg <= ST_ROUND;
               end else if (exp_reg > EXP_ONE) begin
                  mag_reg <= {mag_reg[EXT_W-1:0], 1'b0};
                  exp_reg <= exp_reg - EXP_ONE;
               end else begin
                  result_reg    <= {sign_reg, {(W-1){1'b0}}};
                  flags_reg     <= FLAGS_UNF;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_DONE;
               end
            end
            ST_ROUND: begin
               if (rnd_exp >= EXP_MAX) begin
                  result_reg <= {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  flags_reg  <= FLAGS_OVF;
               end else begin
                  result_reg <= {sign_reg, rnd_exp[EXP_W-1:0], rnd_frac};
                  flags_reg  <= (rnd_g | rnd_r | rnd_s) ? FLAGS_INEXACT : FLAGS_NONE;
               end
               out_valid_reg <= 1'b1;
               state_reg     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               state_reg    <= ST_IDLE;
               in_ready_reg <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Bench for fpu_addsub_seq: vector table through a result scoreboard, plus
// special-operand latency, output back-pressure and mid-operation reset sequences.
module tb_fpu_addsub_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   localparam int NV = 19;
   vec_t tbl [NV];
   exp_t sb [$];
   exp_t mon_e;

`ifdef FPU_RNE_EN
   localparam logic [31:0] EXP_ODD_TIE = 32'h3F800002;
   localparam logic [31:0] EXP_ABOVE_H = 32'h3F800001;
`else
   localparam logic [31:0] EXP_ODD_TIE = 32'h3F800001;
   localparam logic [31:0] EXP_ABOVE_H = 32'h3F800000;
`endif

   fpu_addsub_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Scoreboard side: every retired result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, expected no result", out_result);
         end else begin
            mon_e = sb.pop_front();
            $display("txn %s: result %h flags %b", mon_e.name, out_result, out_flags);
            check({mon_e.name, "_result"}, out_result, mon_e.res);
            check({mon_e.name, "_flags"}, {28'd0, out_flags}, {28'd0, mon_e.flg});
         end
      end
   end

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_ready_timeout: in_ready %b, expected 1", tag, in_ready);
      end
   endtask

   task automatic send(input string name, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic [3:0] flg,
                       input bit push);
      exp_t e;
      @(negedge clk);
      wait_ready(name);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      if (push) begin
         e.name = name;
         e.res  = res;
         e.flg  = flg;
         sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_timeout: %0d results outstanding, expected 0", tag, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;

      tbl[0]  = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000}; // 1+1 carry
      tbl[1]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000}; // exact zero
      tbl[2]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101}; // overflow
      tbl[3]  = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000}; // inf-inf
      tbl[4]  = '{1'b0, 32'h3F800000, 32'h30800000, 32'h3F800000, 4'b0001}; // sticky bypass
      tbl[5]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001}; // tie, even
      tbl[6]  = '{1'b0, 32'h3F800001, 32'h33800000, EXP_ODD_TIE,  4'b0001}; // tie, odd
      tbl[7]  = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000}; // 3-1
      tbl[8]  = '{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000}; // swap + left norm
      tbl[9]  = '{1'b0, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b0000}; // NaN in
      tbl[10] = '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000}; // inf+x
      tbl[11] = '{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000}; // x-inf
      tbl[12] = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000}; // -0+-0
      tbl[13] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000}; // 0-0
      tbl[14] = '{1'b0, 32'h00400000, 32'h3F800000, 32'h3F800000, 4'b0000}; // subnormal in
      tbl[15] = '{1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 4'b0011}; // underflow flush
      tbl[16] = '{1'b0, 32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000}; // inf+inf
      tbl[17] = '{1'b0, 32'h3F800000, 32'h33C00000, EXP_ABOVE_H,  4'b0001}; // above half
      tbl[18] = '{1'b0, 32'h3F800000, 32'h3F800001, 32'h40000000, 4'b0001}; // carry with G

      repeat (3) @(negedge clk);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", out_result, 32'd0);
      check("reset_flags", {28'd0, out_flags}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         send($sformatf("v%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].flg, 1'b1);
         drain($sformatf("v%0d", i));
      end

      // Special operands reach DONE on the cycle right after acceptance.
      @(negedge clk);
      wait_ready("lat");
      in_valid = 1'b1;
      in_op    = 1'b1;
      in_a     = 32'h7F800000;
      in_b     = 32'h7F800000;
      sb.push_back('{"lat_special", 32'h7FC00000, 4'b1000});
      @(negedge clk);
      in_valid = 1'b0;
      check("lat_special_valid", {31'd0, out_valid}, 32'd1);
      check("lat_special_in_ready", {31'd0, in_ready}, 32'd0);
      drain("lat_special");

      // Back-pressure: result and flags must hold while out_ready is low.
      out_ready = 1'b0;
      send("hold", 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b1);
      for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         check("hold_result", out_result, 32'h40000000);
         check("hold_flags", {28'd0, out_flags}, 32'd0);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      drain("hold");

      // Reset while the next op is still aligning: nothing may come out.
      send("abort", 1'b0, 32'h3F800000, 32'h33800000, 32'h0, 4'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_result", out_result, 32'd0);
      repeat (40) @(negedge clk);
      check("abort_quiet", {31'd0, out_valid}, 32'd0);

      send("recover", 1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 1'b1);
      drain("recover");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
